// File: rtl/pwm_ramp_pkg.sv
// pwm_ramp_pkg: shared channel-state encoding and default widths for the PWM ramp controller.
package pwm_ramp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, REQ} chan_st_e;
  localparam int DUTY_W_DEF = 12;
  localparam int DIV_W_DEF = 16;
endpackage

// File: rtl/pwm_ramp_chan.sv
// pwm_ramp_chan: one ramp engine holding cur/tgt/step/interval and the IDLE/WAIT/REQ sequencing.
module pwm_ramp_chan
  import pwm_ramp_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              reset_p,
  input  logic              i_load,
  input  logic [DUTY_W-1:0] i_target,
  input  logic [DUTY_W-1:0] i_step,
  input  logic [DIV_W-1:0]  i_interval,
  input  logic              i_ack,
  input  logic [DUTY_W-1:0] i_duty,
  output logic              o_req,
  output logic              o_busy,
  output logic              o_done,
  output logic [DUTY_W-1:0] o_next
);
  chan_st_e r_st, w_st_nxt;
  logic [DUTY_W-1:0] r_cur, r_tgt, r_step, w_step;
  logic [DIV_W-1:0] r_ivl, r_cnt, w_ivl;
  logic [DUTY_W:0] w_up, w_dn;
  logic r_done, w_done_nxt;
  assign w_step = (|i_step) ? i_step : DUTY_W'(1);
  assign w_ivl = (|i_interval) ? i_interval : DIV_W'(1);
  // One extra bit so overshoot above full scale or below zero clamps to tgt instead of wrapping
  assign w_up = {1'b0, r_cur} + {1'b0, r_step};
  assign w_dn = {1'b0, r_cur} - {1'b0, r_step};
  assign o_next = (r_cur < r_tgt) ? ((w_up > {1'b0, r_tgt}) ? r_tgt : w_up[DUTY_W-1:0])
                : ((w_dn[DUTY_W] || w_dn[DUTY_W-1:0] < r_tgt) ? r_tgt : w_dn[DUTY_W-1:0]);
  assign o_req = r_st == REQ;
  assign o_busy = r_st != IDLE;
  assign o_done = r_done;
  always_comb begin
    w_st_nxt = r_st;
    w_done_nxt = 1'b0;
    if (i_load) begin
      w_st_nxt = (i_target == r_cur) ? IDLE : WAIT;
      w_done_nxt = i_target == r_cur;
    end else if (i_ack) begin
      w_st_nxt = (i_duty == r_tgt) ? IDLE : WAIT;
      w_done_nxt = i_duty == r_tgt;
    end else if (r_st == WAIT && r_cnt <= DIV_W'(1)) begin
      w_st_nxt = REQ;
    end
  end
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_st <= IDLE;
      r_cur <= '0;
      r_tgt <= '0;
      r_step <= '0;
      r_ivl <= '0;
      r_cnt <= '0;
      r_done <= 1'b0;
    end else begin
      r_st <= w_st_nxt;
      r_done <= w_done_nxt;
      if (i_load) begin
        r_tgt <= i_target;
        r_step <= w_step;
        r_ivl <= w_ivl;
        r_cnt <= w_ivl;
      end else if (i_ack) begin
        r_cur <= i_duty;
        r_cnt <= r_ivl;
      end else if (r_st == WAIT) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: CH ramp engines sharing one round-robin arbitrated, registered duty-update stream.
// Optional PWM_RAMP_IRQ_EN adds sticky per-channel done bits (irq_clr in, irq out).
module pwm_ramp_ctrl
  import pwm_ramp_pkg::*;
#(
  parameter int CH = 4,
  parameter int DUTY_W = DUTY_W_DEF,
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic                   clk,
  input  logic                   reset_p,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [$clog2(CH)-1:0]  cmd_ch,
  input  logic [DUTY_W-1:0]      cmd_target,
  input  logic [DUTY_W-1:0]      cmd_step,
  input  logic [DIV_W-1:0]       cmd_interval,
  output logic                   upd_valid,
  input  logic                   upd_ready,
  output logic [$clog2(CH)-1:0]  upd_ch,
  output logic [DUTY_W-1:0]      upd_duty,
  output logic [CH-1:0]          busy,
`ifdef PWM_RAMP_IRQ_EN
  input  logic [CH-1:0]          irq_clr,
  output logic                   irq,
`endif
  output logic [CH-1:0]          done
);
  localparam int CW = $clog2(CH);
  logic [CH-1:0] w_req, w_hit, w_load, w_ack, w_elig;
  logic [DUTY_W-1:0] w_next [CH];
  logic [CW-1:0] r_ptr, w_ptr, w_gnt, w_idx, r_ch;
  logic [DUTY_W-1:0] r_duty;
  logic r_valid, w_hs, w_gnt_ok;
  for (genvar i = 0; i < CH; i++) begin : g_ch
    assign w_hit[i] = cmd_ch == CW'(i);
    assign w_load[i] = cmd_valid && cmd_ready && w_hit[i];
    assign w_ack[i] = w_hs && r_ch == CW'(i);
    // The channel already sitting in the output register must not be granted twice
    assign w_elig[i] = w_req[i] && !(r_valid && r_ch == CW'(i));
    pwm_ramp_chan #(.DUTY_W(DUTY_W), .DIV_W(DIV_W)) u_chan (
      .clk(clk), .reset_p(reset_p), .i_load(w_load[i]), .i_target(cmd_target),
      .i_step(cmd_step), .i_interval(cmd_interval), .i_ack(w_ack[i]), .i_duty(r_duty),
      .o_req(w_req[i]), .o_busy(busy[i]), .o_done(done[i]), .o_next(w_next[i])
    );
  end
  assign cmd_ready = ~|(w_req & w_hit);
  assign w_hs = r_valid && upd_ready;
  assign w_ptr = w_hs ? ((r_ch == CW'(CH - 1)) ? '0 : r_ch + 1'b1) : r_ptr;
  assign upd_valid = r_valid;
  assign upd_ch = r_ch;
  assign upd_duty = r_duty;
  always_comb begin
    w_gnt = '0;
    w_gnt_ok = 1'b0;
    w_idx = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      w_idx = CW'((int'(w_ptr) + k) % CH);
      if (w_elig[w_idx]) begin
        w_gnt = w_idx;
        w_gnt_ok = 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset_p) begin
      r_valid <= 1'b0;
      r_ch <= '0;
      r_duty <= '0;
      r_ptr <= '0;
    end else begin
      r_ptr <= w_ptr;
      if (!r_valid || upd_ready) begin
        r_valid <= w_gnt_ok;
        r_ch <= w_gnt;
        r_duty <= w_next[w_gnt];
      end
    end
  end
`ifdef PWM_RAMP_IRQ_EN
  logic [CH-1:0] r_sticky;
  always_ff @(posedge clk) begin
    if (reset_p) r_sticky <= '0;
    else r_sticky <= (r_sticky & ~irq_clr) | done;
  end
  assign irq = |r_sticky;
`endif
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: directed plus randomized ramps checked against a per-channel expected-duty queue model.
module tb_pwm_ramp_ctrl;
  localparam int CH = 4;
  logic clk = 1'b0, reset_p = 1'b1, cmd_valid = 1'b0, upd_ready = 1'b1;
  logic cmd_ready, upd_valid, rdy_s;
  logic [1:0] cmd_ch = '0, upd_ch;
  logic [11:0] cmd_target = '0, cmd_step = '0, upd_duty;
  logic [15:0] cmd_interval = '0;
  logic [CH-1:0] busy, done;
`ifdef PWM_RAMP_IRQ_EN
  logic [CH-1:0] irq_clr = '0;
  logic irq;
`endif
  int n_cmp = 0, n_err = 0, cyc = 0;
  int exp_q[CH][$];
  int model_cur[CH], exp_done[CH], got_done[CH];
  int grant_q[$], cyc_q[$];

  always #5 clk = ~clk;

  pwm_ramp_ctrl dut (
    .clk(clk), .reset_p(reset_p), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_target(cmd_target), .cmd_step(cmd_step), .cmd_interval(cmd_interval),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_ch(upd_ch), .upd_duty(upd_duty),
    .busy(busy),
`ifdef PWM_RAMP_IRQ_EN
    .irq_clr(irq_clr), .irq(irq),
`endif
    .done(done)
  );

  task automatic chk(string tag, int obs, int expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock cycle: observe at the falling edge, return just after the next rising edge
  task automatic tick();
    @(negedge clk);
    rdy_s = cmd_ready;
    if (!reset_p) begin
      for (int i = 0; i < CH; i++) if (done[i]) got_done[i]++;
      if (upd_valid && upd_ready) begin
        int c;
        c = int'(upd_ch);
        grant_q.push_back(c);
        cyc_q.push_back(cyc);
        chk($sformatf("upd_expected ch%0d", c), (exp_q[c].size() > 0) ? 1 : 0, 1);
        if (exp_q[c].size() > 0) begin
          int e;
          e = exp_q[c].pop_front();
          chk($sformatf("upd_duty ch%0d", c), int'(upd_duty), e);
          model_cur[c] = e;
          if (exp_q[c].size() == 0) exp_done[c]++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send(int ch, int tgt, int stp, int ivl);
    int s, c, guard;
    cmd_valid = 1'b1;
    cmd_ch = 2'(ch);
    cmd_target = 12'(tgt);
    cmd_step = 12'(stp);
    cmd_interval = 16'(ivl);
    guard = 0;
    do begin
      tick();
      guard++;
    end while (!rdy_s && guard < 200);
    cmd_valid = 1'b0;
    chk("cmd_accept", int'(rdy_s), 1);
    s = (stp == 0) ? 1 : stp;
    c = model_cur[ch];
    exp_q[ch].delete();
    if (tgt == c) exp_done[ch]++;
    while (c != tgt) begin
      c = (c < tgt) ? ((c + s > tgt) ? tgt : c + s) : ((c - s < tgt) ? tgt : c - s);
      exp_q[ch].push_back(c);
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < CH; i++) p += exp_q[i].size();
    return p;
  endfunction

  task automatic wait_idle(int maxc, bit rnd);
    int n = 0;
    while (n < maxc && (busy != '0 || upd_valid || pending() != 0)) begin
      if (rnd) upd_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    chk("wait_idle_in_budget", (n < maxc) ? 1 : 0, 1);
    upd_ready = 1'b1;
    tick();
    tick();
    for (int i = 0; i < CH; i++) chk($sformatf("done_count ch%0d", i), got_done[i], exp_done[i]);
  endtask

  task automatic clear_model();
    for (int i = 0; i < CH; i++) begin
      exp_q[i].delete();
      model_cur[i] = 0;
      exp_done[i] = 0;
      got_done[i] = 0;
    end
  endtask

  initial begin
    int n, tgt, stp;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_upd_valid", int'(upd_valid), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    reset_p = 1'b0;
    tick();
    chk("post_rst_upd_valid", int'(upd_valid), 0);

    // Single channel ramp: interval cycles of WAIT, then one REQ cycle and the registered handshake
    cyc_q.delete();
    send(0, 100, 25, 10);
    wait_idle(300, 1'b0);
    chk("r28_updates", cyc_q.size(), 4);
    for (int k = 1; k < cyc_q.size(); k++) chk("r28_gap", cyc_q[k] - cyc_q[k-1], 12);

    send(1, 4095, 2000, 1);
    wait_idle(300, 1'b0);
    grant_q.delete();
    send(1, 0, 1000, 1);
    wait_idle(300, 1'b0);
    chk("r29_updates", grant_q.size(), 5);

    grant_q.delete();
    cyc_q.delete();
    for (int i = 0; i < CH; i++) send(i, 4000, 500, 1);
    wait_idle(500, 1'b0);
    chk("r30_grants", grant_q.size(), 32);
    for (int k = 0; k < 16 && k < grant_q.size(); k++) chk("r30_rotate", grant_q[k], k % 4);
    for (int k = 1; k < 16 && k < cyc_q.size(); k++) chk("r30_back_to_back", cyc_q[k] - cyc_q[k-1], 1);

    upd_ready = 1'b0;
    send(2, 100, 1000, 1);
    n = 0;
    while (!upd_valid && n < 50) begin
      tick();
      n++;
    end
    chk("r31_valid", int'(upd_valid), 1);
    for (int k = 0; k < 20; k++) begin
      cmd_ch = (k % 2 == 0) ? 2'd2 : 2'd0;
      tick();
      chk("r31_upd_ch", int'(upd_ch), 2);
      chk("r31_upd_duty", int'(upd_duty), 3000);
      chk("r31_cmd_ready", int'(rdy_s), (k % 2 == 0) ? 0 : 1);
    end
    upd_ready = 1'b1;
    wait_idle(300, 1'b0);

    send(0, 0, 4000, 1);
    wait_idle(100, 1'b0);
    send(0, 4000, 200, 3);
    n = 0;
    while (model_cur[0] != 400 && n < 200) begin
      tick();
      n++;
    end
    chk("r32_reached_400", (n < 200) ? 1 : 0, 1);
    grant_q.delete();
    send(0, 10, 200, 1);
    wait_idle(200, 1'b0);
    chk("r32_retarget_updates", grant_q.size(), 2);

    send(0, 4000, 100, 2);
    repeat (15) tick();
    chk("r32_midramp_busy", int'(busy[0]), 1);
    reset_p = 1'b1;
    tick();
    chk("r32_rst_busy", int'(busy), 0);
    chk("r32_rst_upd_valid", int'(upd_valid), 0);
    chk("r32_rst_done", int'(done), 0);
    chk("r32_rst_cmd_ready", int'(cmd_ready), 1);
    reset_p = 1'b0;
    clear_model();
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("r32_release_upd_valid", int'(upd_valid), 0);
    end
    grant_q.delete();
    send(0, 50, 50, 1);
    send(3, 0, 7, 1);
    wait_idle(100, 1'b0);
    chk("r32_cur_from_zero_updates", grant_q.size(), 1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < CH; i++) begin
        tgt = $urandom_range(0, 4095);
        stp = $urandom_range(150, 1200);
        if ($urandom_range(0, 7) == 0) begin
          stp = 0;
          tgt = (model_cur[i] >= 3) ? model_cur[i] - 3 : model_cur[i] + 3;
        end
        if ($urandom_range(0, 7) == 0) tgt = model_cur[i];
        send(i, tgt, stp, $urandom_range(0, 4));
      end
      wait_idle(4000, 1'b1);
    end

`ifdef PWM_RAMP_IRQ_EN
    irq_clr = '1;
    tick();
    irq_clr = '0;
    chk("irq_cleared", int'(irq), 0);
    send(3, model_cur[3], 5, 1);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("irq_held", int'(irq), 1);
    end
    irq_clr = 4'b1000;
    tick();
    irq_clr = '0;
    chk("irq_clr3", int'(irq), 0);
    send(3, model_cur[3], 5, 1);
    irq_clr = 4'b1000;
    tick();
    irq_clr = '0;
    chk("irq_set_wins", int'(irq), 1);
    wait_idle(50, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
